idma_desc64_stream_reshaper: RTL and testbench
==============================================

# idma_desc64_stream_reshaper

Streaming successor to the combinational desc64 reshaper. It accepts the 256-bit descriptor as a stream of DataWidth-bit beats from the descriptor fetch path and assembles them in place. It reshapes the descriptor into an iDMA backend request and presents it on a valid/ready port with a one-entry output register. It adds per-descriptor max burst-length selection, end-of-chain detection and abort of a partially received descriptor.

## Interface
- idma_req_t, logic: backend request struct, with the same opt fields as the desc64 frontend.
- addr_t, logic: address type, 64 bits.
- DataWidth, 64: beat width; legal values are 64, 128 and 256. NumBeats = 256/DataWidth.
- MaxLlenEn, 1'b1: if 1, src/dst_max_llen come from flags; if 0, they are tied to '0.
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset; synchronous and active-low.
- desc_valid_i  in  1  descriptor beat valid.
- desc_ready_o  out  1  descriptor beat accepted.
- desc_data_i  in  DataWidth  beat data; the lowest descriptor word comes first.
- abort_i  in  1  discards the partially assembled descriptor.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request accepted.
- req_o  out  idma_req_t  reshaped request.
- next_addr_o  out  addr_t  descriptor next field.
- do_irq_o  out  1  flags[0].
- last_o  out  1  end of chain: next == '1.
- busy_o  out  1  a partial descriptor is held or req_valid_o is high.

## Operation
- Descriptor word order (64-bit words): w0 = {flags[31:0], length[31:0]}, w1 = next, w2 = src_addr, w3 = dest_addr. A beat of DataWidth carries DataWidth/64 consecutive words, lowest index in the LSBs.
- The beat counter runs 0..NumBeats-1 and wraps to 0 after the final beat. Non-final beats are written into the assembly buffer, which holds NumBeats-1 beats; for DataWidth=256 the buffer is empty.
- Final beat: the buffer contents plus the incoming beat are reshaped combinationally and loaded into the output register. req_valid_o is set.
- Reshape mapping:
  - length, src_addr, dst_addr come from the corresponding descriptor fields.
  - src_protocol = flags[26:24]; dst_protocol = flags[29:27]; axi_id = flags[23:16].
  - src.burst = flags[2:1]; dst.burst = flags[4:3]; src.cache = flags[11:8]; dst.cache = flags[15:12].
  - lock, prot, qos and region are 0.
  - decouple_rw = flags[5]; decouple_aw = flags[6]; src_reduce_len = dst_reduce_len = flags[7].
  - src_max_llen = dst_max_llen = {1'b0, flags[31:30]} when MaxLlenEn; otherwise '0.
- next_addr_o, do_irq_o and last_o are registered alongside req_o and are valid while req_valid_o is high.
- desc_ready_o = rst_ni & ~abort_i & (counter != NumBeats-1 | ~req_valid_o | req_ready_i). Non-final beats are accepted even while the output register is occupied. The final beat is accepted when the register is empty or is being drained in the same cycle.
- Output handshake: req_valid_o is cleared on req_valid_o & req_ready_i, unless a final beat loads in the same cycle, in which case it stays high with the new contents.
- abort_i: the counter is reset to 0 and any beat presented that cycle is dropped, since desc_ready_o is 0. The output register is unaffected, so a completed request is never discarded.

## Timing
- Latency: the final beat is accepted in cycle N and req_valid_o is high in cycle N+1. There is no combinational path from desc_data_i to req_o.
- Throughput: one descriptor per NumBeats cycles with no bubbles under continuous req_ready_i. For DataWidth=256 this is one descriptor per cycle.
- Once req_valid_o is raised, req_o and the sidecar outputs are stable until the handshake.
- Reset, while rst_ni is low at a clock edge: the counter is 0. req_valid_o, req_o, next_addr_o, do_irq_o, last_o and busy_o are all 0. desc_ready_o is 0 while rst_ni is low and 1 in the first cycle after release.
- Reset mid-descriptor: partial beats and any pending request are lost. The next beat after reset is treated as w0.
- Simultaneous abort_i and final beat: abort wins, the beat is not accepted and the counter goes to 0.

## Test plan
- DataWidth=64, beats {flags=32'h0700_00A5, length=32'h100}, next=64'h8000, src=64'h1000, dst=64'h2000 with req_ready_i=1 -> req_valid_o is high one cycle after the 4th beat.
  - Required request fields: length=0x100, src_addr=0x1000, dst_addr=0x2000, src.burst=2'b10, dst.burst=2'b00, decouple_rw=1, reduce_len=1, src_protocol=3'd7.
  - Required sidecar outputs: do_irq_o=1, last_o=0.
- DataWidth=256, 3 back-to-back descriptors with req_ready_i=1 -> 3 consecutive req_valid_o cycles with no bubble and data in order.
- DataWidth=64, req_ready_i=0 while 2 descriptors stream in -> beats 0..2 of descriptor 2 are accepted and desc_ready_o is 0 on beat 3.
  - Raising req_ready_i lets beat 3 be accepted in the same cycle and descriptor 2 appears in the next cycle.
- next=64'hFFFF_FFFF_FFFF_FFFF and flags[31:30]=2'b11 -> last_o=1 and max_llen=3'd3 with MaxLlenEn=1; max_llen=0 with MaxLlenEn=0.
- DataWidth=128, abort_i asserted after beat 0 -> a subsequent 2-beat descriptor is reshaped correctly.
  - abort_i coinciding with a final beat -> that beat is not accepted.
- rst_ni low for 1 cycle after beat 2 of a 64-bit descriptor -> all outputs 0, and a fresh 4-beat descriptor is reshaped correctly.

Source files
------------

// File: rtl/idma_desc64_stream_reshaper.sv
// idma_desc64_stream_reshaper
//
// Collects a 256-bit desc64 descriptor that arrives as NumBeats beats of
// DataWidth bits. It reshapes the descriptor into an iDMA backend request and
// holds the result in a one-entry output register.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   desc_valid_i/ready_o     descriptor beat handshake
//   desc_data_i              descriptor beat; the lowest descriptor word comes first
//   abort_i                  drops a partially received descriptor
//   req_valid_o/ready_i      request handshake
//   req_o                    reshaped request (bit layout is idma_req_t)
//   next_addr_o              descriptor next field
//   do_irq_o                 flags[0]
//   last_o                   next field is all ones (end of chain)
//   busy_o                   partial descriptor held or request pending
//
// Handshake rule for both ports: a transfer happens in a cycle where valid
// and ready are both high at the rising edge. Once valid is raised, the payload
// is held stable until that transfer.

package idma_desc64_stream_reshaper_pkg;

  typedef struct packed {
    logic [2:0]  src_max_llen;
    logic [2:0]  dst_max_llen;
    logic        src_reduce_len;
    logic        dst_reduce_len;
    logic        decouple_rw;
    logic        decouple_aw;
    logic [7:0]  axi_id;
    logic [2:0]  src_protocol;
    logic [2:0]  dst_protocol;
    logic [1:0]  src_burst;
    logic [3:0]  src_cache;
    logic        src_lock;
    logic [2:0]  src_prot;
    logic [3:0]  src_qos;
    logic [3:0]  src_region;
    logic [1:0]  dst_burst;
    logic [3:0]  dst_cache;
    logic        dst_lock;
    logic [2:0]  dst_prot;
    logic [3:0]  dst_qos;
    logic [3:0]  dst_region;
    logic [63:0] dst_addr;
    logic [63:0] src_addr;
    logic [31:0] length;
  } idma_req_t;

  localparam int unsigned ReqWidth = $bits(idma_req_t);

endpackage

module idma_desc64_stream_reshaper
  import idma_desc64_stream_reshaper_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter bit          MaxLlenEn = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [DataWidth-1:0] desc_data_i,
  input  logic                 abort_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [ReqWidth-1:0]  req_o,
  output logic [63:0]          next_addr_o,
  output logic                 do_irq_o,
  output logic                 last_o,
  output logic                 busy_o
);

  localparam int unsigned NumBeats = 256 / DataWidth;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  logic [CntW-1:0] cnt_q;
  logic            req_valid_q;
  idma_req_t       req_q;
  logic [63:0]     next_q;
  logic            irq_q;
  logic            last_q;

  logic            is_final;
  logic            beat_fire;
  logic [255:0]    desc_full;
  logic [31:0]     flags;
  logic [63:0]     next_d;
  idma_req_t       req_d;

  assign is_final = (cnt_q == LastBeat);

  // The final beat can only be taken when the output register is free or
  // drains in the same cycle. Earlier beats only fill the assembly buffer.
  assign desc_ready_o = rst_ni & ~abort_i & (~is_final | ~req_valid_q | req_ready_i);
  assign beat_fire    = desc_valid_i & desc_ready_o;

  // Assembly buffer for all beats except the final one. The final beat goes
  // straight into the reshape logic, so a full descriptor never needs a
  // register stage of its own.
  if (NumBeats > 1) begin : g_buf
    logic [DataWidth-1:0] asm_q [NumBeats-1];

    always_ff @(posedge clk_i) begin
      if (beat_fire && !is_final) begin
        for (int i = 0; i < NumBeats - 1; i++) begin
          if (cnt_q == CntW'(i)) asm_q[i] <= desc_data_i;
        end
      end
    end

    always_comb begin
      desc_full = '0;
      for (int i = 0; i < NumBeats - 1; i++) begin
        desc_full[i*DataWidth +: DataWidth] = asm_q[i];
      end
      desc_full[256-DataWidth +: DataWidth] = desc_data_i;
    end
  end else begin : g_nobuf
    assign desc_full = desc_data_i;
  end

  // Word layout: w0 = {flags, length}, w1 = next, w2 = src, w3 = dst.
  assign flags  = desc_full[63:32];
  assign next_d = desc_full[127:64];

  always_comb begin
    req_d                = '0;
    req_d.length         = desc_full[31:0];
    req_d.src_addr       = desc_full[191:128];
    req_d.dst_addr       = desc_full[255:192];
    req_d.src_protocol   = flags[26:24];
    req_d.dst_protocol   = flags[29:27];
    req_d.axi_id         = flags[23:16];
    req_d.src_burst      = flags[2:1];
    req_d.dst_burst      = flags[4:3];
    req_d.src_cache      = flags[11:8];
    req_d.dst_cache      = flags[15:12];
    req_d.decouple_rw    = flags[5];
    req_d.decouple_aw    = flags[6];
    req_d.src_reduce_len = flags[7];
    req_d.dst_reduce_len = flags[7];
    req_d.src_max_llen   = {1'b0, flags[31:30]} & {3{MaxLlenEn}};
    req_d.dst_max_llen   = {1'b0, flags[31:30]} & {3{MaxLlenEn}};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      next_q      <= '0;
      irq_q       <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      if (abort_i) begin
        cnt_q <= '0;
      end else if (beat_fire) begin
        cnt_q <= is_final ? '0 : cnt_q + 1'b1;
      end

      // A load in the same cycle as a drain keeps valid high with new contents.
      if (beat_fire && is_final) begin
        req_valid_q <= 1'b1;
        req_q       <= req_d;
        next_q      <= next_d;
        irq_q       <= flags[0];
        last_q      <= &next_d;
      end else if (req_ready_i) begin
        req_valid_q <= 1'b0;
      end
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_o       = req_q;
  assign next_addr_o = next_q;
  assign do_irq_o    = irq_q;
  assign last_o      = last_q;
  assign busy_o      = req_valid_q | (cnt_q != '0);

endmodule

// File: tb/tb_idma_desc64_stream_reshaper.sv
// Bench for idma_desc64_stream_reshaper. It uses four instances:
//   k=0: DataWidth 64,  MaxLlenEn 1
//   k=1: DataWidth 64,  MaxLlenEn 0 (shares every input with k=0)
//   k=2: DataWidth 128, MaxLlenEn 1
//   k=3: DataWidth 256, MaxLlenEn 1
// A descriptor-level model collects the accepted words per instance. It pushes
// the expected request into exp_q when a descriptor completes and checks all
// outputs on every falling edge.
module tb_idma_desc64_stream_reshaper;
  import idma_desc64_stream_reshaper_pkg::*;

  localparam int EXP_W = ReqWidth + 66;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]          rst_n, dvalid, abort, rready;
  logic [3:0]          dready, rvalid, irq, last, busy;
  logic [255:0]        ddata [4];
  logic [ReqWidth-1:0] req [4];
  logic [63:0]         nxt [4];

  int n_checks = 0;
  int n_errors = 0;

  idma_desc64_stream_reshaper #(.DataWidth(64), .MaxLlenEn(1'b1)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n[0]), .desc_valid_i(dvalid[0]), .desc_ready_o(dready[0]),
    .desc_data_i(ddata[0][63:0]), .abort_i(abort[0]), .req_valid_o(rvalid[0]),
    .req_ready_i(rready[0]), .req_o(req[0]), .next_addr_o(nxt[0]), .do_irq_o(irq[0]),
    .last_o(last[0]), .busy_o(busy[0]));

  idma_desc64_stream_reshaper #(.DataWidth(64), .MaxLlenEn(1'b0)) u_dut64n (
    .clk_i(clk), .rst_ni(rst_n[0]), .desc_valid_i(dvalid[0]), .desc_ready_o(dready[1]),
    .desc_data_i(ddata[0][63:0]), .abort_i(abort[0]), .req_valid_o(rvalid[1]),
    .req_ready_i(rready[0]), .req_o(req[1]), .next_addr_o(nxt[1]), .do_irq_o(irq[1]),
    .last_o(last[1]), .busy_o(busy[1]));

  idma_desc64_stream_reshaper #(.DataWidth(128), .MaxLlenEn(1'b1)) u_dut128 (
    .clk_i(clk), .rst_ni(rst_n[2]), .desc_valid_i(dvalid[2]), .desc_ready_o(dready[2]),
    .desc_data_i(ddata[2][127:0]), .abort_i(abort[2]), .req_valid_o(rvalid[2]),
    .req_ready_i(rready[2]), .req_o(req[2]), .next_addr_o(nxt[2]), .do_irq_o(irq[2]),
    .last_o(last[2]), .busy_o(busy[2]));

  idma_desc64_stream_reshaper #(.DataWidth(256), .MaxLlenEn(1'b1)) u_dut256 (
    .clk_i(clk), .rst_ni(rst_n[3]), .desc_valid_i(dvalid[3]), .desc_ready_o(dready[3]),
    .desc_data_i(ddata[3]), .abort_i(abort[3]), .req_valid_o(rvalid[3]),
    .req_ready_i(rready[3]), .req_o(req[3]), .next_addr_o(nxt[3]), .do_irq_o(irq[3]),
    .last_o(last[3]), .busy_o(busy[3]));

  // ---------------- check helper ----------------
  task automatic check(string name, logic [EXP_W-1:0] act, logic [EXP_W-1:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s @%0t: actual=%h required=%h", name, $time, act, exp_v);
    end
  endtask

  function automatic int nb_of(int k);
    return (k == 2) ? 2 : (k == 3) ? 1 : 4;
  endfunction

  function automatic int src_of(int k);
    return (k == 1) ? 0 : k;
  endfunction

  // Expected output tuple {request, next, irq, last}, built from the four
  // descriptor words.
  function automatic logic [EXP_W-1:0] make_exp(logic [63:0] w0, logic [63:0] w1,
                                                logic [63:0] w2, logic [63:0] w3, bit mle);
    idma_req_t   r;
    logic [31:0] f;
    f = w0[63:32];
    r = '0;
    r.length         = w0[31:0];
    r.src_addr       = w2;
    r.dst_addr       = w3;
    r.src_protocol   = f[26:24];
    r.dst_protocol   = f[29:27];
    r.axi_id         = f[23:16];
    r.src_burst      = f[2:1];
    r.dst_burst      = f[4:3];
    r.src_cache      = f[11:8];
    r.dst_cache      = f[15:12];
    r.decouple_rw    = f[5];
    r.decouple_aw    = f[6];
    r.src_reduce_len = f[7];
    r.dst_reduce_len = f[7];
    if (mle) begin
      r.src_max_llen = {1'b0, f[31:30]};
      r.dst_max_llen = {1'b0, f[31:30]};
    end
    return {r, w1, f[0], (w1 == 64'hFFFF_FFFF_FFFF_FFFF)};
  endfunction

  // ---------------- model / scoreboard ----------------
  logic [EXP_W-1:0] exp_q [4][$];
  int          cnt_m [4];
  logic [63:0] words_m [4][4];
  logic        acc_m [4];
  logic        drain_m [4];
  logic        rst_seen [4];
  bit          model_on = 1'b0;

  // Compare on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    int s;
    logic er;
    logic [EXP_W-1:0] act;
    if (model_on) begin
      for (int k = 0; k < 4; k++) begin
        s   = src_of(k);
        er  = rst_n[s] & ~abort[s] &
              ((cnt_m[k] != nb_of(k) - 1) | (exp_q[k].size() == 0) | rready[s]);
        act = {req[k], nxt[k], irq[k], last[k]};
        check($sformatf("desc_ready_o[%0d]", k), dready[k], er);
        check($sformatf("req_valid_o[%0d]", k), rvalid[k], exp_q[k].size() != 0);
        check($sformatf("busy_o[%0d]", k), busy[k], (exp_q[k].size() != 0) || (cnt_m[k] != 0));
        if (exp_q[k].size() != 0) check($sformatf("request[%0d]", k), act, exp_q[k][0]);
        if (rst_seen[k]) check($sformatf("reset outputs[%0d]", k), act, '0);
        acc_m[k]   = dvalid[s] & er;
        drain_m[k] = (exp_q[k].size() != 0) & rready[s];
      end
    end
  end

  always @(posedge clk) begin
    int s, wpb;
    for (int k = 0; k < 4; k++) begin
      s = src_of(k);
      rst_seen[k] = !rst_n[s];
      if (!rst_n[s]) begin
        cnt_m[k] = 0;
        exp_q[k].delete();
      end else if (model_on) begin
        if (drain_m[k]) void'(exp_q[k].pop_front());
        if (abort[s]) begin
          cnt_m[k] = 0;
        end else if (acc_m[k]) begin
          wpb = 4 / nb_of(k);
          for (int j = 0; j < wpb; j++) words_m[k][cnt_m[k]*wpb + j] = ddata[s][64*j +: 64];
          if (cnt_m[k] == nb_of(k) - 1) begin
            exp_q[k].push_back(make_exp(words_m[k][0], words_m[k][1], words_m[k][2],
                                        words_m[k][3], k != 1));
            cnt_m[k] = 0;
          end else begin
            cnt_m[k]++;
          end
        end
      end
    end
    model_on = 1'b1;
  end

  // Run-length monitor for the 256-bit back-to-back test.
  int run256 = 0, max_run256 = 0, total256 = 0;
  always @(negedge clk) begin
    if (rvalid[3] === 1'b1) begin
      run256++;
      total256++;
      if (run256 > max_run256) max_run256 = run256;
    end else begin
      run256 = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put_beat(int k, logic [255:0] beat);
    bit ok;
    ok = 1'b0;
    dvalid[k] = 1'b1;
    ddata[k]  = beat;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      ok = dready[k];
      @(posedge clk);
      #1;
      if (ok) break;
    end
    check("beat accept timeout", ok, 1'b1);
  endtask

  task automatic send_desc(int k, logic [63:0] w0, logic [63:0] w1,
                           logic [63:0] w2, logic [63:0] w3);
    logic [255:0] d;
    int n;
    d = {w3, w2, w1, w0};
    n = nb_of(k);
    for (int b = 0; b < n; b++) put_beat(k, d >> (b * (256 / n)));
    dvalid[k] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  idma_req_t r0, r1;

  initial begin
    rst_n  = '0;
    dvalid = '0;
    abort  = '0;
    rready = '0;
    for (int k = 0; k < 4; k++) ddata[k] = '0;
    repeat (2) step();
    @(negedge clk);
    check("ready low in reset", dready[0], 1'b0);
    check("busy low in reset", busy[0], 1'b0);
    step();
    rst_n = '1;
    @(negedge clk);
    check("ready after reset", dready[0], 1'b1);
    step();

    // Basic 64-bit descriptor.
    rready[0] = 1'b1;
    send_desc(0, 64'h0700_00A5_0000_0100, 64'h8000, 64'h1000, 64'h2000);
    @(negedge clk);
    r0 = idma_req_t'(req[0]);
    check("t1 valid", rvalid[0], 1'b1);
    check("t1 length", r0.length, 32'h100);
    check("t1 src_addr", r0.src_addr, 64'h1000);
    check("t1 dst_addr", r0.dst_addr, 64'h2000);
    check("t1 src_burst", r0.src_burst, 2'b10);
    check("t1 dst_burst", r0.dst_burst, 2'b00);
    check("t1 decouple_rw", r0.decouple_rw, 1'b1);
    check("t1 reduce_len", {r0.src_reduce_len, r0.dst_reduce_len}, 2'b11);
    check("t1 src_protocol", r0.src_protocol, 3'd7);
    check("t1 do_irq", irq[0], 1'b1);
    check("t1 last", last[0], 1'b0);
    step();

    // End of chain and max_llen, with MaxLlenEn set and cleared.
    send_desc(0, 64'hC000_0000_0000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3000, 64'h4000);
    @(negedge clk);
    r0 = idma_req_t'(req[0]);
    r1 = idma_req_t'(req[1]);
    check("t4 last", last[0], 1'b1);
    check("t4 last nollen", last[1], 1'b1);
    check("t4 src_max_llen", r0.src_max_llen, 3'd3);
    check("t4 dst_max_llen", r0.dst_max_llen, 3'd3);
    check("t4 max_llen disabled", {r1.src_max_llen, r1.dst_max_llen}, 6'd0);
    step();

    // Backpressure: the final beat of the second descriptor waits.
    rready[0] = 1'b0;
    send_desc(0, 64'h0000_0001_0000_0200, 64'h9000, 64'h5000, 64'h6000);
    put_beat(0, 64'h0000_0018_0000_0300);
    put_beat(0, 64'hA000);
    put_beat(0, 64'h5100);
    dvalid[0] = 1'b1;
    ddata[0]  = 64'h6100;
    repeat (2) begin
      @(negedge clk);
      check("t3 final beat blocked", dready[0], 1'b0);
      step();
    end
    rready[0] = 1'b1;
    @(negedge clk);
    check("t3 final beat accepted", dready[0], 1'b1);
    check("t3 first request held", nxt[0], 64'h9000);
    step();
    dvalid[0] = 1'b0;
    @(negedge clk);
    check("t3 second valid", rvalid[0], 1'b1);
    check("t3 second next", nxt[0], 64'hA000);
    step();

    // 256-bit back-to-back descriptors.
    rready[3] = 1'b1;
    put_beat(3, {64'h2100, 64'h1100, 64'hC001, 64'h0000_0002_0000_0010});
    put_beat(3, {64'h2200, 64'h1200, 64'hC002, 64'h0000_0004_0000_0020});
    put_beat(3, {64'h2300, 64'h1300, 64'hC003, 64'h0000_0008_0000_0030});
    dvalid[3] = 1'b0;
    repeat (3) step();
    check("t2 no bubble run", max_run256, 3);
    check("t2 total requests", total256, 3);

    // 128-bit abort after beat 0, then a clean descriptor.
    rready[2] = 1'b1;
    put_beat(2, {64'h1, 64'hDEAD_0000_0000_0001});
    dvalid[2] = 1'b1;
    abort[2]  = 1'b1;
    ddata[2]  = {64'hBEEF, 64'hBEEF};
    @(negedge clk);
    check("t5 abort blocks beat", dready[2], 1'b0);
    step();
    abort[2]  = 1'b0;
    dvalid[2] = 1'b0;
    send_desc(2, 64'h0000_2040_0000_0400, 64'hB000, 64'h7000, 64'h8000);
    @(negedge clk);
    check("t5 valid", rvalid[2], 1'b1);
    check("t5 next", nxt[2], 64'hB000);
    step();

    // Abort on the final beat.
    put_beat(2, {64'hC100, 64'h0000_0001_0000_0500});
    dvalid[2] = 1'b1;
    abort[2]  = 1'b1;
    ddata[2]  = {64'hE000, 64'hD000};
    @(negedge clk);
    check("t5 abort final beat", dready[2], 1'b0);
    step();
    abort[2]  = 1'b0;
    dvalid[2] = 1'b0;
    @(negedge clk);
    check("t5 no request after abort", rvalid[2], 1'b0);
    check("t5 idle after abort", busy[2], 1'b0);
    send_desc(2, 64'h0000_00FE_0000_0600, 64'hC200, 64'hD100, 64'hE100);
    @(negedge clk);
    check("t5 post-abort next", nxt[2], 64'hC200);
    step();

    // Reset with a pending request and a partial descriptor.
    rready[0] = 1'b0;
    send_desc(0, 64'h0000_0001_0000_0700, 64'hD000, 64'h1111, 64'h2222);
    put_beat(0, 64'h0000_0000_0000_0800);
    put_beat(0, 64'hE000);
    put_beat(0, 64'h3333);
    dvalid[0] = 1'b0;
    rst_n[0]  = 1'b0;
    @(negedge clk);
    check("t6 ready in reset", dready[0], 1'b0);
    step();
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("t6 valid cleared", rvalid[0], 1'b0);
    check("t6 busy cleared", busy[0], 1'b0);
    check("t6 req cleared", req[0], '0);
    check("t6 next cleared", nxt[0], 64'h0);
    check("t6 ready after reset", dready[0], 1'b1);
    step();
    rready[0] = 1'b1;
    send_desc(0, 64'h0000_3011_0000_0900, 64'hF000, 64'h4444, 64'h5555);
    @(negedge clk);
    check("t6 fresh valid", rvalid[0], 1'b1);
    check("t6 fresh next", nxt[0], 64'hF000);
    step();

    rready = '1;
    repeat (5) step();
    for (int k = 0; k < 4; k++) check($sformatf("queue drained[%0d]", k), exp_q[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
